// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel registered valid/ready mux with fixed-priority
// or round-robin arbitration, packet locking and winner index output.
//
// Ports: clk, resetn (async, active-low); in_valid/in_ready/in_data/
// in_last per channel; out_valid/out_ready/out_data/out_last/out_idx
// registered output beat; busy high while a packet lock is held.
module rr_arb_mux #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 4,
  parameter int RR_MODE  = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_CH-1:0]   in_valid,
  output logic [NUM_CH-1:0]   in_ready,
  input  logic [WIDTH-1:0]    in_data [NUM_CH-1:0],
  input  logic [NUM_CH-1:0]   in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic [IDX_BITS-1:0] out_idx,
  output logic                busy
);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_BITS-1:0] lock_ch;
  logic [IDX_BITS-1:0] lock_nxt;
  logic [IDX_BITS-1:0] ptr;
  logic [IDX_BITS-1:0] ptr_nxt;
  logic [IDX_BITS-1:0] gnt;
  logic                gnt_vld;
  logic [IDX_BITS-1:0] hi_idx;
  logic                hi_vld;
  logic [IDX_BITS-1:0] lo_idx;
  logic                lo_vld;
  logic [WIDTH-1:0]    sel_data;
  logic                sel_last;
  logic                load;
  logic                xfer;

  assign load = !out_valid || out_ready;
  assign busy = (state == LOCKED);

  // Round-robin search split in two: requesters above ptr win first,
  // the lowest requester at or below ptr is the wrap-around fallback.
  always_comb begin
    hi_idx = '0;
    hi_vld = 1'b0;
    lo_idx = '0;
    lo_vld = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (in_valid[c]) begin
        if (IDX_BITS'(c) > ptr) begin
          hi_idx = IDX_BITS'(c);
          hi_vld = 1'b1;
        end else begin
          lo_idx = IDX_BITS'(c);
          lo_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (state == LOCKED) begin
      gnt = lock_ch;
      for (int c = 0; c < NUM_CH; c++) begin
        if (IDX_BITS'(c) == lock_ch) begin
          gnt_vld = in_valid[c];
        end
      end
    end else if (RR_MODE == 0) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (in_valid[c]) begin
          gnt     = IDX_BITS'(c);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      gnt     = hi_vld ? hi_idx : lo_idx;
      gnt_vld = hi_vld || lo_vld;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    in_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (IDX_BITS'(c) == gnt) begin
        sel_data    = in_data[c];
        sel_last    = in_last[c];
        in_ready[c] = load && resetn && gnt_vld;
      end
    end
  end

  assign xfer = |in_ready;

  // ptr moves only on last beats so a packet is one RR turn.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    ptr_nxt   = ptr;
    if (xfer) begin
      if (!sel_last) begin
        state_nxt = LOCKED;
        lock_nxt  = gnt;
      end else begin
        state_nxt = UNLOCKED;
        if (RR_MODE != 0) begin
          ptr_nxt = gnt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= UNLOCKED;
      lock_ch <= '0;
      ptr     <= IDX_BITS'(NUM_CH - 1);
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
      ptr     <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_idx   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: scoreboard bench for rr_arb_mux (RR instance) plus
// direct checks on a fixed-priority instance.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [W-1:0] in_data [N-1:0];
  logic [N-1:0] in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [3:0]   out_idx;
  logic         busy;

  logic [N-1:0] fp_valid;
  logic [N-1:0] fp_ready;
  logic [W-1:0] fp_data [N-1:0];
  logic [N-1:0] fp_last;
  logic         fp_ovalid;
  logic         fp_oready;
  logic [W-1:0] fp_odata;
  logic         fp_olast;
  logic [3:0]   fp_oidx;
  logic         fp_busy;

  always #5 clk = ~clk;

  rr_arb_mux #(
    .NUM_CH(N), .WIDTH(W),
    .IDX_BITS(4), .RR_MODE(1)
  ) u_rr (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .out_idx(out_idx),
    .busy(busy)
  );

  rr_arb_mux #(
    .NUM_CH(N), .WIDTH(W),
    .IDX_BITS(4), .RR_MODE(0)
  ) u_fp (
    .clk(clk), .resetn(resetn),
    .in_valid(fp_valid),
    .in_ready(fp_ready),
    .in_data(fp_data),
    .in_last(fp_last),
    .out_valid(fp_ovalid),
    .out_ready(fp_oready),
    .out_data(fp_odata),
    .out_last(fp_olast),
    .out_idx(fp_oidx),
    .busy(fp_busy)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [32:0] src_q [N][$];
  beat_t       exp_q [$];
  logic [N-1:0] hold;
  logic [N-1:0] acc;
  bit          sb_en;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic src(input int c, input logic [31:0] d,
                     input logic l);
    src_q[c].push_back({l, d});
  endtask

  task automatic want(input int c, input logic [31:0] d,
                      input logic l);
    exp_q.push_back('{idx: 4'(c), data: d, last: l});
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() > 0 && !hold[c]) begin
        in_valid[c] = 1'b1;
        in_data[c]  = src_q[c][0][31:0];
        in_last[c]  = src_q[c][0][32];
      end else begin
        in_valid[c] = 1'b0;
        in_data[c]  = '0;
        in_last[c]  = 1'b0;
      end
    end
  endtask

  task automatic sample();
    beat_t e;
    @(negedge clk);
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", {out_idx, out_data}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idx", out_idx, e.idx);
        chk("sb_data", out_data, e.data);
        chk("sb_last", out_last, e.last);
      end
    end
    acc = in_valid & in_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++)
      if (acc[c]) void'(src_q[c].pop_front());
    drive();
  endtask

  task automatic run(input int max, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      sample();
      advance();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  int n;
  logic [3:0] pat [8];

  initial begin
    resetn    = 1'b0;
    hold      = '0;
    acc       = '0;
    sb_en     = 1'b1;
    out_ready = 1'b0;
    fp_valid  = '0;
    fp_last   = '0;
    fp_oready = 1'b0;
    for (int c = 0; c < N; c++) begin
      in_data[c] = '0;
      fp_data[c] = W'(c + 32'h100);
    end
    in_last  = '0;
    in_valid = 4'b0001;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    drive();

    // fixed priority: ch1 beats ch3
    fp_oready = 1'b1;
    fp_last   = 4'hF;
    fp_valid  = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fp_rdy", fp_ready, 4'b0010);
      if (i > 0) chk("fp_idx", fp_oidx, 1);
      @(posedge clk);
      #1;
    end
    fp_valid = 4'b1000;
    @(negedge clk);
    chk("fp_rdy3", fp_ready, 4'b1000);
    @(posedge clk);
    #1;
    fp_valid = '0;
    @(negedge clk);
    chk("fp_idx3", fp_oidx, 3);
    chk("fp_data3", fp_odata, 32'h103);
    @(posedge clk);
    #1;

    // round-robin fairness, 1 beat/cycle
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N; c++)
        src(c, 32'((c << 4) | k), 1'b1);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N; c++)
        want(c, 32'((c << 4) | k), 1'b1);
    drive();
    run(40, n);
    chk("rr_tput", n, 13);

    // packet lock: put ptr at 1 first
    src(1, 32'h5F, 1'b1);
    want(1, 32'h5F, 1'b1);
    drive();
    run(10, n);
    src(2, 32'hA0, 1'b0);
    src(2, 32'hA1, 1'b0);
    src(2, 32'hA2, 1'b1);
    src(0, 32'h0C, 1'b1);
    want(2, 32'hA0, 1'b0);
    want(2, 32'hA1, 1'b0);
    want(2, 32'hA2, 1'b1);
    want(0, 32'h0C, 1'b1);
    drive();
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      sample();
      if (out_valid && out_idx == 4'd2) begin
        if (out_data != 32'hA2) begin
          chk("lk_busy", busy, 1);
          chk("lk_rdy0", in_ready[0], 0);
        end else begin
          chk("lk_free", busy, 0);
        end
      end
      advance();
      n++;
    end
    chk("lk_drain", exp_q.size(), 0);

    // backpressure
    pat = '{4'd1, 4'd0, 4'd0, 4'd1,
            4'd1, 4'd1, 4'd1, 4'd1};
    src(1, 32'h11, 1'b1);
    src(1, 32'h22, 1'b1);
    src(1, 32'h33, 1'b1);
    want(1, 32'h11, 1'b1);
    want(1, 32'h22, 1'b1);
    want(1, 32'h33, 1'b1);
    drive();
    for (int i = 0; i < 8; i++) begin
      out_ready = pat[i][0];
      sample();
      if (i == 1 || i == 2) begin
        chk("bp_ov", out_valid, 1);
        chk("bp_hold", out_data, 32'h11);
        chk("bp_rdy", in_ready, 0);
      end
      advance();
    end
    out_ready = 1'b1;
    run(10, n);

    // locked source gap
    src(0, 32'hB0, 1'b0);
    src(0, 32'hB1, 1'b1);
    src(1, 32'hC0, 1'b1);
    want(0, 32'hB0, 1'b0);
    want(0, 32'hB1, 1'b1);
    want(1, 32'hC0, 1'b1);
    drive();
    sample();
    hold[0] = 1'b1;
    advance();
    sample();
    chk("gap_rdy", in_ready, 0);
    chk("gap_busy", busy, 1);
    advance();
    sample();
    chk("gap_ov", out_valid, 0);
    chk("gap_rdy2", in_ready, 0);
    hold[0] = 1'b0;
    advance();
    run(20, n);

    // reset mid-packet
    sb_en = 1'b0;
    src(2, 32'hD0, 1'b0);
    src(2, 32'hD1, 1'b0);
    src(2, 32'hD2, 1'b1);
    drive();
    sample();
    advance();
    sample();
    chk("pre_ov", out_valid, 1);
    chk("pre_busy", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_idx", out_idx, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rdy", in_ready, 0);
    for (int c = 0; c < N; c++)
      src_q[c].delete();
    acc = '0;
    drive();
    advance();
    resetn = 1'b1;
    sb_en  = 1'b1;
    src(3, 32'hE3, 1'b1);
    src(0, 32'hE0, 1'b1);
    want(0, 32'hE0, 1'b1);
    want(3, 32'hE3, 1'b1);
    drive();
    run(10, n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel registered multiplexer with arbitration and packet locking. It is the sequential successor to the combinational one-hot select muxes in the datapath. Up to 16 valid/ready producer channels compete for one registered valid/ready output. The block selects a winner by fixed priority or round-robin, holds the grant until a packet's last beat, and reports the winning channel index with each output beat.

## Interface
Parameters:
- NUM_CH, 4, number of input channels; legal range 2..16.
- WIDTH, 32, data width per channel.
- IDX_BITS, 4, width of out_idx; must satisfy 2^IDX_BITS >= NUM_CH.
- RR_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- in_valid  in  NUM_CH  per-channel beat valid.
- in_ready  out  NUM_CH  per-channel accept; at most one bit high.
- in_data  in  WIDTH x NUM_CH (unpacked array [NUM_CH-1:0])  per-channel data.
- in_last  in  NUM_CH  per-channel end-of-packet marker.
- out_valid  out  1  registered output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  registered data of the accepted beat.
- out_last  out  1  registered last flag of the accepted beat.
- out_idx  out  IDX_BITS  channel index that produced the current output beat.
- busy  out  1  high while a packet lock is held.

## Operation
- Transfer in: in_valid[c] && in_ready[c]. Transfer out: out_valid && out_ready.
- load = !out_valid || out_ready. The output register accepts a beat only when load is high. There is no skid buffer.
- States:
  - UNLOCKED (reset state). The arbiter picks grant g from the valid channels.
    - RR_MODE=0: lowest valid index wins.
    - RR_MODE=1: first valid index strictly after ptr, wrapping at NUM_CH-1 → 0.
  - LOCKED. g is frozen at lock_ch. Other channels' in_valid are ignored.
- in_ready[g] = load && in_valid[g] && resetn. All other bits are 0. in_ready is combinational from in_valid, out_valid, out_ready and state.
- On an input transfer from g:
  - out_data ← in_data[g], out_last ← in_last[g], out_idx ← g, out_valid ← 1.
  - If in_last[g]=0: enter LOCKED with lock_ch=g.
  - If in_last[g]=1: go to or stay in UNLOCKED. In RR_MODE=1, ptr ← g.
- ptr updates only on last beats, so a multi-beat packet counts as one round-robin turn.
- Output transfer with no new input transfer: out_valid ← 0. The other output registers hold.
- busy = (state == LOCKED).
- If a locked channel drops in_valid mid-packet, the lock holds and the output idles until that channel resumes.
- A single-channel case (one valid requester) behaves identically in both modes.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle sustained while out_ready=1, including back-to-back packets from different channels with no bubble.
- out_ready=0 with out_valid=1:
  - all in_ready=0;
  - out_data, out_last and out_idx stable;
  - arbitration result may change while unlocked, but nothing is consumed.
- Reset (resetn low, asynchronous assert):
  - out_valid=0, out_data=0, out_last=0, out_idx=0;
  - state=UNLOCKED, ptr=NUM_CH-1 (channel 0 wins first in RR), busy=0;
  - in_ready=0 while resetn low.
- Reset mid-packet: the lock is dropped and the in-flight output beat is discarded. The first cycle after deassertion arbitrates from the reset state.
- Simultaneous output drain and new input load in the same cycle: the new beat replaces the old one. out_valid stays 1.

## Test plan
- Reset: drive resetn low mid-stream with out_valid=1 → out_valid, out_idx, busy = 0 and in_ready=0 immediately. After release, ch0 request is granted first.
- Round-robin fairness: NUM_CH=4, RR_MODE=1, all channels hold single-beat packets, out_ready=1 → out_idx sequence 0,1,2,3,0,1… with one beat every cycle after 1-cycle latency.
- Fixed priority: RR_MODE=0, ch1 and ch3 valid continuously → out_idx always 1. Ch3 is never ready until ch1 drops.
- Packet lock: ch2 sends 3 beats (last on the 3rd, data 0xA0..0xA2) while ch0 is valid → output 0xA0,0xA1,0xA2 with out_idx=2 and busy=1 for beats 1–2. The next beat comes from ch0 (RR ptr=2 → 3 absent → 0).
- Backpressure: out_ready toggles 1,0,0,1 while ch1 streams 0x11,0x22,0x33 → out_data holds stable while stalled. No beat is lost or duplicated, and in_ready[1]=0 in stalled cycles.
- Locked-source gap: ch0 sends a non-last beat, then drops in_valid for 2 cycles while ch1 is valid → no ch1 beat is granted and out_valid=0 during the gap. Ch0 completes, then ch1 is granted.
